// File: rtl/usb_txn_ctrl.sv
// Device-side USB transaction sequencer: decodes token/data/handshake PIDs,
// schedules handshakes or IN data, tracks DATA0/DATA1 toggles and bus turnaround.
module usb_txn_ctrl #(
   parameter int TIMEOUT_CYCLES = 128,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [2:0] rx_packet,
   input  logic       rx_data_ready,
   input  logic       rx_transfer_active,
   input  logic       rx_error,
   input  logic       tx_done,
   input  logic       tx_error,
   input  logic [6:0] buffer_occupancy,
   input  logic       host_ready,
   output logic [2:0] tx_packet,
   output logic       tx_start,
   output logic       d_mode,
   output logic       flush,
   output logic       rx_done,
   output logic       tx_acked,
   output logic       txn_error,
   output logic       busy
);

   localparam logic [2:0] PID_OUT   = 3'd0;
   localparam logic [2:0] PID_IN    = 3'd1;
   localparam logic [2:0] PID_DATA0 = 3'd2;
   localparam logic [2:0] PID_DATA1 = 3'd3;
   localparam logic [2:0] PID_ACK   = 3'd4;

   localparam logic [2:0] TX_NONE  = 3'd0;
   localparam logic [2:0] TX_DATA0 = 3'd1;
   localparam logic [2:0] TX_DATA1 = 3'd2;
   localparam logic [2:0] TX_ACK   = 3'd3;
   localparam logic [2:0] TX_NAK   = 3'd4;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      IDLE, OUT_WAIT, OUT_CHECK, IN_CHECK, SEND_HS, SEND_DATA,
      HS_WAIT, DATA_WAIT, ACK_WAIT, ERR
   } state_t;

   state_t            state_reg, state_next;
   logic              rx_ready_q_reg;
   logic [CNT_W-1:0]  timer_reg;
   logic              rx_toggle_reg, rx_toggle_next;
   logic              tx_toggle_reg, tx_toggle_next;
   logic              data_pid_reg, data_pid_next;
   logic [2:0]        tx_packet_reg, tx_packet_next;
   logic              rx_done_reg, rx_done_next;
   logic              tx_acked_reg, tx_acked_next;
   logic              txn_error_reg, txn_error_next;
   logic              flush_reg, flush_next;

   logic pkt_evt, timeout, is_data, timer_clr;

   // Zero-length IN packets are sent exactly like full ones, so occupancy is informational only.
   logic unused_occupancy;
   assign unused_occupancy = ^buffer_occupancy;

   assign pkt_evt   = rx_data_ready & ~rx_ready_q_reg;
   assign timeout   = (timer_reg == TMO_LAST);
   assign is_data   = (rx_packet == PID_DATA0) || (rx_packet == PID_DATA1);
   assign timer_clr = (state_next != state_reg) &&
                      ((state_next == OUT_WAIT) || (state_next == ACK_WAIT));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg      <= IDLE;
         rx_ready_q_reg <= 1'b0;
         timer_reg      <= '0;
         rx_toggle_reg  <= 1'b0;
         tx_toggle_reg  <= 1'b0;
         data_pid_reg   <= 1'b0;
         tx_packet_reg  <= TX_NONE;
         rx_done_reg    <= 1'b0;
         tx_acked_reg   <= 1'b0;
         txn_error_reg  <= 1'b0;
         flush_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         rx_ready_q_reg <= rx_data_ready;
         rx_toggle_reg  <= rx_toggle_next;
         tx_toggle_reg  <= tx_toggle_next;
         data_pid_reg   <= data_pid_next;
         tx_packet_reg  <= tx_packet_next;
         rx_done_reg    <= rx_done_next;
         tx_acked_reg   <= tx_acked_next;
         txn_error_reg  <= txn_error_next;
         flush_reg      <= flush_next;
         if (timer_clr)
            timer_reg <= '0;
         else if (!rx_transfer_active && (timer_reg != '1))
            timer_reg <= timer_reg + 1'b1;
      end
   end

   always_comb begin
      state_next     = state_reg;
      rx_toggle_next = rx_toggle_reg;
      tx_toggle_next = tx_toggle_reg;
      data_pid_next  = data_pid_reg;
      tx_packet_next = tx_packet_reg;
      rx_done_next   = 1'b0;
      tx_acked_next  = 1'b0;
      txn_error_next = 1'b0;
      flush_next     = 1'b0;

      case (state_reg)
         IDLE: begin
            if (rx_error)
               state_next = ERR;
            else if (pkt_evt && (rx_packet == PID_OUT))
               state_next = OUT_WAIT;
            else if (pkt_evt && (rx_packet == PID_IN))
               state_next = IN_CHECK;
         end
         OUT_WAIT: begin
            if (rx_error)
               state_next = ERR;
            else if (pkt_evt) begin
               if (is_data) begin
                  state_next    = OUT_CHECK;
                  data_pid_next = rx_packet[0];
               end else begin
                  state_next = ERR;
               end
            end else if (timeout)
               state_next = ERR;
         end
         OUT_CHECK: begin
            tx_packet_next = TX_ACK;
            state_next     = SEND_HS;
            // A toggle mismatch is a host retry of data already accepted: ACK it, drop the copy.
            if (data_pid_reg == rx_toggle_reg) begin
               rx_toggle_next = ~rx_toggle_reg;
               rx_done_next   = 1'b1;
            end else begin
               flush_next = 1'b1;
            end
         end
         IN_CHECK: begin
            if (host_ready) begin
               tx_packet_next = tx_toggle_reg ? TX_DATA1 : TX_DATA0;
               state_next     = SEND_DATA;
            end else begin
               tx_packet_next = TX_NAK;
               state_next     = SEND_HS;
            end
         end
         SEND_HS:   state_next = HS_WAIT;
         SEND_DATA: state_next = DATA_WAIT;
         HS_WAIT: begin
            if (rx_error || tx_error)
               state_next = ERR;
            else if (tx_done)
               state_next = IDLE;
         end
         DATA_WAIT: begin
            if (rx_error || tx_error)
               state_next = ERR;
            else if (tx_done)
               state_next = ACK_WAIT;
         end
         ACK_WAIT: begin
            if (rx_error)
               state_next = ERR;
            else if (pkt_evt) begin
               state_next = IDLE;
               if (rx_packet == PID_ACK) begin
                  tx_toggle_next = ~tx_toggle_reg;
                  tx_acked_next  = 1'b1;
               end else begin
                  txn_error_next = 1'b1;
               end
            end else if (timeout) begin
               state_next     = IDLE;
               txn_error_next = 1'b1;
            end
         end
         ERR: begin
            if (!rx_transfer_active)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if ((state_next == ERR) && (state_reg != ERR)) begin
         txn_error_next = 1'b1;
         flush_next     = (state_reg == OUT_WAIT);
      end
      if ((state_next == IDLE) || (state_next == ERR))
         tx_packet_next = TX_NONE;
   end

   assign tx_packet = tx_packet_reg;
   assign tx_start  = (state_reg == SEND_HS) || (state_reg == SEND_DATA);
   assign d_mode    = (state_reg == SEND_HS) || (state_reg == SEND_DATA) ||
                      (state_reg == HS_WAIT) || (state_reg == DATA_WAIT);
   assign flush     = flush_reg;
   assign rx_done   = rx_done_reg;
   assign tx_acked  = tx_acked_reg;
   assign txn_error = txn_error_reg;
   assign busy      = (state_reg != IDLE);

endmodule
